// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int BIN_W   = 20;
  localparam int DIGITS  = 6;
  localparam int MAX_DEC = 10**DIGITS - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One double-dabble correction cell: a BCD digit >= 5 gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Add-3 correction, purely combinational
  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, saturating at
// the largest value the display can show, with an overflow flag.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = bin_to_bcd_seq_pkg::BIN_W,
  parameter int DIGITS = bin_to_bcd_seq_pkg::DIGITS
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  bin_valid,
  input  logic [BIN_W-1:0]      bin_data,
  output logic                  bin_ready,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_data,
  output logic                  bcd_ovf
);

  localparam int               ACC_W     = 4*DIGITS;
  localparam int               CNT_W     = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAX_DEC_W = BIN_W'(10**DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_adj;
  logic               ovf_r_q, ovf_r_d;
  logic               ready_q, ready_d;
  logic               bcd_valid_q, bcd_valid_d;
  logic [ACC_W-1:0]   bcd_data_q, bcd_data_d;
  logic               bcd_ovf_q, bcd_ovf_d;
  logic               over;

  // Saturation keeps the top digit <= 9, so the accumulator never carries out
  assign over = (bin_data > MAX_DEC_W);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (acc_q[4*g +: 4]),
      .q (acc_adj[4*g +: 4])
    );
  end

  // Next-state logic for the IDLE -> SHIFT x BIN_W -> DONE sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    ovf_r_d     = ovf_r_q;
    ready_d     = ready_q;
    bcd_valid_d = 1'b0;
    bcd_data_d  = bcd_data_q;
    bcd_ovf_d   = bcd_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bin_valid) begin
          sh_d    = over ? MAX_DEC_W : bin_data;
          ovf_r_d = over;
          acc_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_d, sh_d} = {acc_adj, sh_q} << 1;
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Outputs only ever change here, so no partial result is visible
        bcd_data_d  = acc_q;
        bcd_ovf_d   = ovf_r_q;
        bcd_valid_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any conversion in flight
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      acc_q       <= '0;
      ovf_r_q     <= 1'b0;
      ready_q     <= 1'b1;
      bcd_valid_q <= 1'b0;
      bcd_data_q  <= '0;
      bcd_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      ovf_r_q     <= ovf_r_d;
      ready_q     <= ready_d;
      bcd_valid_q <= bcd_valid_d;
      bcd_data_q  <= bcd_data_d;
      bcd_ovf_q   <= bcd_ovf_d;
    end
  end

  assign bin_ready = ready_q;
  assign bcd_valid = bcd_valid_q;
  assign bcd_data  = bcd_data_q;
  assign bcd_ovf   = bcd_ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with a scoreboard of expected results.
module tb_bin_to_bcd_seq;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        bin_valid;
  logic [19:0] bin_data;
  logic        bin_ready;
  logic        bcd_valid;
  logic [23:0] bcd_data;
  logic        bcd_ovf;

  typedef struct {
    logic [23:0] data;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   cyc    = 0;

  bin_to_bcd_seq dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .bin_valid (bin_valid),
    .bin_data  (bin_data),
    .bin_ready (bin_ready),
    .bcd_valid (bcd_valid),
    .bcd_data  (bcd_data),
    .bcd_ovf   (bcd_ovf)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: saturate, then convert by repeated division
  function automatic logic [23:0] model(input logic [19:0] v);
    int          x;
    logic [23:0] r;
    x = (v > 20'd999999) ? 999999 : int'(v);
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Output side of the scoreboard
  exp_t e;
  always @(negedge sys_clk) begin
    if (rst_n && bcd_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("bcd_data", 32'(bcd_data), 32'(e.data));
        chk("bcd_ovf", 32'(bcd_ovf), 32'(e.ovf));
        chk("latency", 32'(cyc - e.cyc), 32'd21);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bin_ready && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (!bin_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [19:0] v);
    exp_t x;
    x.data = model(v);
    x.ovf  = (v > 20'd999999);
    x.cyc  = cyc + 1;
    sb.push_back(x);
  endtask

  // Present one word for a single accept cycle
  task automatic send(input logic [19:0] v);
    wait_ready();
    bin_valid = 1'b1;
    bin_data  = v;
    push(v);
    @(posedge sys_clk); #1;
    bin_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge sys_clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bin_ready), 32'd1);
    chk({tag, "_valid"}, 32'(bcd_valid), 32'd0);
    chk({tag, "_data"},  32'(bcd_data),  32'd0);
    chk({tag, "_ovf"},   32'(bcd_ovf),   32'd0);
  endtask

  logic [19:0] words [5];
  int          n;
  int          prev;

  initial begin
    rst_n     = 1'b0;
    bin_valid = 1'b0;
    bin_data  = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // zero still takes the full conversion
    send(20'd0);
    drain();

    // typical value, busy window length
    send(20'd123456);
    n = 0;
    while (!bin_ready && n < 100) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("ready_low_cycles", 32'(n), 32'd21);
    drain();

    // saturation boundary
    send(20'd999999);   drain();
    send(20'd1000000);  drain();
    send(20'hFFFFF);    drain();

    // words offered while busy are dropped
    send(20'd500000);
    repeat (3) begin @(posedge sys_clk); #1; end
    bin_valid = 1'b1; bin_data = 20'd7;
    chk("busy_ready_a", 32'(bin_ready), 32'd0);
    @(posedge sys_clk); #1;
    bin_valid = 1'b0;
    repeat (9) begin @(posedge sys_clk); #1; end
    bin_valid = 1'b1; bin_data = 20'd7;
    chk("busy_ready_b", 32'(bin_ready), 32'd0);
    chk("hold_data", 32'(bcd_data), 32'h999999);
    chk("hold_ovf", 32'(bcd_ovf), 32'd1);
    @(posedge sys_clk); #1;
    bin_valid = 1'b0;
    drain();
    repeat (30) @(posedge sys_clk);
    #1;

    // valid held high: back-to-back conversions
    words[0] = 20'd1;
    words[1] = 20'd314159;
    words[2] = 20'd1000001;
    words[3] = 20'd86400;
    words[4] = 20'd999990;
    bin_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ready();
      bin_data = words[i];
      push(words[i]);
      if (i > 0) chk("b2b_interval", 32'(cyc + 1 - prev), 32'd22);
      prev = cyc + 1;
      @(posedge sys_clk); #1;
      bin_data = 20'($urandom);
    end
    bin_valid = 1'b0;
    drain();

    // reset in the middle of a conversion
    send(20'd654321);
    repeat (9) begin @(posedge sys_clk); #1; end
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    sb.delete();
    repeat (3) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge sys_clk);
    #1;
    chk("post_rst_data", 32'(bcd_data), 32'd0);
    send(20'd42);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
